mult_err_acc: RTL and testbench
===============================

# mult_err_acc

Sequential error-characterisation stage that sits directly downstream of an 8x8 approximate multiplier. Each accepted sample carries the operands A and B and the multiplier's 16-bit approximate product R. The block recomputes the exact product and accumulates error metrics over a run of N_SAMPLES samples:
- sum of error distance (ED)
- maximum ED
- count of erroneous samples
- signed error sum

Mean ED, error rate and bias are then derived in software.

## Interface
Parameters:
- N_SAMPLES, 256: samples per run. Legal range is 1..65535.
- CNT_W, $clog2(N_SAMPLES+1): localparam, width of the sample and error counters.
- SUM_W, 16+CNT_W: localparam, width of the ED sum.

Ports:
- clk, input, 1: single clock. All logic is rising-edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: single-cycle pulse that clears the accumulators and begins a run.
- in_valid, input, 1: sample present on a/b/r_approx.
- in_ready, output, 1: block accepts a sample this cycle.
- a, input, 8: multiplicand, as fed to the approximate multiplier.
- b, input, 8: multiplier operand.
- r_approx, input, 16: approximate product for (a, b).
- busy, output, 1: high in RUN and DRAIN.
- done, output, 1: high in DONE; results are valid.
- sum_ed, output, SUM_W: Σ|r_approx − a·b|.
- max_ed, output, 16: max |r_approx − a·b| over the run.
- err_cnt, output, CNT_W: number of samples with r_approx ≠ a·b.
- sum_err, output, SUM_W+1: signed Σ(r_approx − a·b), two's complement.

## Operation
- FSM states:
  - IDLE: in_ready=0. start → RUN.
  - RUN: in_ready = (acc_cnt < N_SAMPLES). When the N_SAMPLES-th sample is accepted → DRAIN.
  - DRAIN: in_ready=0. Once the pipeline is empty → DONE.
  - DONE: in_ready=0 and done=1. start → RUN.
- A sample is accepted when in_valid && in_ready. Samples are never dropped or duplicated.
- Stage 1 (accept cycle edge): register a·b (exact, 16-bit unsigned), r_approx and a valid bit.
- Stage 2 (next edge):
  - diff = r_approx − exact as 17-bit signed.
  - ED = |diff| in 16 bits. It cannot overflow, because the max ED is 65535.
  - sum_ed += ED.
  - sum_err += sign-extended diff.
  - max_ed = max(max_ed, ED).
  - err_cnt += (diff ≠ 0).
- All arithmetic is unsigned except diff and sum_err. SUM_W is sized so that no accumulator can wrap within N_SAMPLES.
- start clears all four result registers and the accepted-sample counter on the same edge that enters RUN.
- start while in RUN or DRAIN is ignored.
- Result outputs hold their values in DONE and IDLE until the next start.
- in_valid is ignored outside RUN. a, b and r_approx are don't-care when in_valid=0.

## Timing
- Reset (rst=1 at an edge): state=IDLE; in_ready, busy and done are 0; every result output is 0; pipeline valid bits are 0.
- Reset mid-run aborts the run with no partial results kept. This holds in any state.
- Start latency: start sampled at edge k → in_ready=1 at cycle k+1.
- Throughput: one sample per cycle, with no back-pressure inside RUN.
- Result latency: a sample accepted at edge k is reflected in the result registers after edge k+2.
- Run completion:
  - Last sample accepted at edge k → in_ready=0 from cycle k+1.
  - DRAIN covers cycles k+1..k+2.
  - done=1 from cycle k+3 onward.
- Results update only when a stage-2 valid bit is set. Valid gaps (in_valid=0) stall nothing, they only insert bubbles.
- start and rst asserted in the same cycle: rst wins.

## Structure
- Shared package approx_mult_pkg: PROD_W=16, OPND_W=8, and the FSM state enum (ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE).
- One sub-module, ed_unit: combinational; inputs exact[15:0] and approx[15:0]; outputs diff[16:0] (signed), ed[15:0] and mismatch.
- The top level holds the FSM, the two pipeline stages and the accumulators.
- Bench connects r_approx either to the real approximate 8x8 multiplier or to a behavioural model.

## Test plan
- Exact model, N_SAMPLES=4: r_approx = a·b for samples (3,5), (255,255), (0,7), (16,16) → sum_ed=0, max_ed=0, err_cnt=0, sum_err=0, done at cycle k+3 after the 4th accept.
- Fixed offset, N_SAMPLES=4: r_approx = a·b+3 on all samples → sum_ed=12, max_ed=3, err_cnt=4, sum_err=+12.
- Mixed sign, N_SAMPLES=3: r_approx = a·b+5, a·b−10, a·b → sum_ed=15, max_ed=10, err_cnt=2, sum_err=−5 (all ones except LSB pattern 0x…FB).
- Extreme ED, N_SAMPLES=2: (a,b)=(255,255) with r_approx=0 twice → max_ed=65025, sum_ed=130050, sum_err=−130050. Checks no wrap.
- Gapped valid plus a mid-run start, N_SAMPLES=4: in_valid toggles 1,0,1,0…, and start is pulsed during RUN → results are identical to the gap-free run, start is ignored, and in_ready deasserts after exactly 4 accepts.
- Reset mid-run: rst after 2 of 4 samples → all outputs 0 and state IDLE on the next cycle. A subsequent start followed by 4 samples yields results for those 4 only.

Source files
------------

// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate-multiplier error-characterisation stage.
//   PROD_W  : width of the exact and approximate products
//   OPND_W  : width of each multiplier operand
//   state_t : run-control FSM states
package approx_mult_pkg;
    localparam int PROD_W = 16;
    localparam int OPND_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/mult_err_acc_if.sv
// Sample stream from the approximate multiplier into the error accumulator.
//   in_valid : sample present on a/b/r_approx
//   in_ready : accumulator takes the sample this cycle
//   a, b     : multiplier operands
//   r_approx : approximate product for (a, b)
interface mult_err_acc_if;
    import approx_mult_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
    logic [PROD_W-1:0] r_approx;

    modport master (output in_valid, a, b, r_approx, input in_ready);
    modport slave  (input in_valid, a, b, r_approx, output in_ready);
endinterface

// File: rtl/mult_err_acc_ed_unit.sv
// Combinational error-distance unit.
//   exact, approx : unsigned products being compared
//   diff          : approx - exact, 17-bit two's complement
//   ed            : |diff|, always fits in 16 bits
//   mismatch      : approx differs from exact
module ed_unit
    import approx_mult_pkg::*;
(
    input  logic [PROD_W-1:0]        exact,
    input  logic [PROD_W-1:0]        approx,
    output logic signed [PROD_W:0]   diff,
    output logic [PROD_W-1:0]        ed,
    output logic                     mismatch
);
    logic [PROD_W:0] neg_diff;

    always_comb begin
        diff     = {1'b0, approx} - {1'b0, exact};
        neg_diff = -diff;
        ed       = diff[PROD_W] ? neg_diff[PROD_W-1:0] : diff[PROD_W-1:0];
        mismatch = (approx != exact);
    end
endmodule

// File: rtl/mult_err_acc.sv
// Error accumulator for an 8x8 approximate multiplier. Each accepted sample
// has its exact product recomputed; ED sum, max ED, error count and signed
// error sum are gathered over a run of N_SAMPLES samples.
//   clk, rst            : clock, synchronous active-high reset
//   start               : one-cycle pulse, clears results and begins a run
//   s_if                : sample stream (slave side)
//   busy, done          : run in progress / results valid
//   sum_ed, max_ed,
//   err_cnt, sum_err    : accumulated error metrics
//
// state    | meaning
// ST_IDLE  | after reset, waiting for start
// ST_RUN   | accepting samples until N_SAMPLES taken
// ST_DRAIN | last sample moving through the two pipeline stages
// ST_DONE  | results final, waiting for the next start
module mult_err_acc
    import approx_mult_pkg::*;
#(
    parameter  int N_SAMPLES = 256,
    localparam int CNT_W     = $clog2(N_SAMPLES + 1),
    localparam int SUM_W     = PROD_W + CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    mult_err_acc_if.slave          s_if,
    output logic                   busy,
    output logic                   done,
    output logic [SUM_W-1:0]       sum_ed,
    output logic [PROD_W-1:0]      max_ed,
    output logic [CNT_W-1:0]       err_cnt,
    output logic signed [SUM_W:0]  sum_err
);
    localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N_SAMPLES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       acc_cnt_q, acc_cnt_d;

    logic                   s1_valid_q, s1_valid_d;
    logic [PROD_W-1:0]      exact_q, exact_d;
    logic [PROD_W-1:0]      approx_q, approx_d;

    logic                   s2_valid_q, s2_valid_d;
    logic signed [PROD_W:0] diff_q, diff_d;
    logic [PROD_W-1:0]      ed_q, ed_d;
    logic                   mism_q, mism_d;

    logic [SUM_W-1:0]       sum_ed_q, sum_ed_d;
    logic [PROD_W-1:0]      max_ed_q, max_ed_d;
    logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;
    logic signed [SUM_W:0]  sum_err_q, sum_err_d;

    logic                   in_ready_w;
    logic                   accept;
    logic signed [PROD_W:0] diff_w;
    logic [PROD_W-1:0]      ed_w;
    logic                   mism_w;

    ed_unit u_ed (
        .exact    (exact_q),
        .approx   (approx_q),
        .diff     (diff_w),
        .ed       (ed_w),
        .mismatch (mism_w)
    );

    always_comb begin
        state_d    = state_q;
        acc_cnt_d  = acc_cnt_q;
        exact_d    = exact_q;
        approx_d   = approx_q;
        diff_d     = diff_q;
        ed_d       = ed_q;
        mism_d     = mism_q;
        sum_ed_d   = sum_ed_q;
        max_ed_d   = max_ed_q;
        err_cnt_d  = err_cnt_q;
        sum_err_d  = sum_err_q;

        in_ready_w = (state_q == ST_RUN) && (acc_cnt_q < N_CNT);
        accept     = s_if.in_valid && in_ready_w;

        // Stage 1: exact product alongside the approximate one.
        s1_valid_d = accept;
        if (accept) begin
            exact_d  = {{(PROD_W-OPND_W){1'b0}}, s_if.a} * {{(PROD_W-OPND_W){1'b0}}, s_if.b};
            approx_d = s_if.r_approx;
        end

        // Stage 2: register the error terms.
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
            diff_d = diff_w;
            ed_d   = ed_w;
            mism_d = mism_w;
        end

        if (s2_valid_q) begin
            sum_ed_d  = sum_ed_q + {{CNT_W{1'b0}}, ed_q};
            sum_err_d = sum_err_q + {{CNT_W{diff_q[PROD_W]}}, diff_q};
            err_cnt_d = err_cnt_q + CNT_W'(mism_q);
            if (ed_q > max_ed_q) begin
                max_ed_d = ed_q;
            end
        end

        // Clearing on start comes last so it overrides any accumulation.
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    acc_cnt_d = '0;
                    sum_ed_d  = '0;
                    max_ed_d  = '0;
                    err_cnt_d = '0;
                    sum_err_d = '0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    acc_cnt_d = acc_cnt_q + CNT_W'(1);
                    if (acc_cnt_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Once stage 1 is empty, stage 2 retires on this edge.
                if (!s1_valid_q) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            acc_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            exact_q    <= '0;
            approx_q   <= '0;
            s2_valid_q <= 1'b0;
            diff_q     <= '0;
            ed_q       <= '0;
            mism_q     <= 1'b0;
            sum_ed_q   <= '0;
            max_ed_q   <= '0;
            err_cnt_q  <= '0;
            sum_err_q  <= '0;
        end else begin
            state_q    <= state_d;
            acc_cnt_q  <= acc_cnt_d;
            s1_valid_q <= s1_valid_d;
            exact_q    <= exact_d;
            approx_q   <= approx_d;
            s2_valid_q <= s2_valid_d;
            diff_q     <= diff_d;
            ed_q       <= ed_d;
            mism_q     <= mism_d;
            sum_ed_q   <= sum_ed_d;
            max_ed_q   <= max_ed_d;
            err_cnt_q  <= err_cnt_d;
            sum_err_q  <= sum_err_d;
        end
    end

    assign s_if.in_ready = in_ready_w;
    assign busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done          = (state_q == ST_DONE);
    assign sum_ed        = sum_ed_q;
    assign max_ed        = max_ed_q;
    assign err_cnt       = err_cnt_q;
    assign sum_err       = sum_err_q;
endmodule

// File: tb/tb_mult_err_acc.sv
// Bench for mult_err_acc with N_SAMPLES=4. Directed runs from the test plan
// plus randomized runs compared against an arithmetic reference model.
module tb_mult_err_acc;
    localparam int N  = 4;
    localparam int CW = $clog2(N + 1);
    localparam int SW = 16 + CW;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic [SW-1:0]     sum_ed;
    logic [15:0]       max_ed;
    logic [CW-1:0]     err_cnt;
    logic signed [SW:0] sum_err;

    mult_err_acc_if m_if ();

    mult_err_acc #(.N_SAMPLES(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .s_if    (m_if),
        .busy    (busy),
        .done    (done),
        .sum_ed  (sum_ed),
        .max_ed  (max_ed),
        .err_cnt (err_cnt),
        .sum_err (sum_err)
    );

    always #5 clk = ~clk;

    int     tests_run    = 0;
    int     tests_failed = 0;
    int     qa[$];
    int     qb[$];
    int     qr[$];
    longint e_sum_ed, e_max_ed, e_err_cnt, e_sum_err;

    task automatic clear_q();
        qa.delete(); qb.delete(); qr.delete();
    endtask

    task automatic push(input int a, input int b, input int r);
        qa.push_back(a); qb.push_back(b); qr.push_back(r);
    endtask

    // Reference: metrics straight from the definitions over the first n samples.
    task automatic model(input int n);
        longint d, ad;
        e_sum_ed = 0; e_max_ed = 0; e_err_cnt = 0; e_sum_err = 0;
        for (int i = 0; i < n; i++) begin
            d  = longint'(qr[i]) - longint'(qa[i]) * longint'(qb[i]);
            ad = (d < 0) ? -d : d;
            e_sum_ed  += ad;
            e_sum_err += d;
            if (d != 0) e_err_cnt++;
            if (ad > e_max_ed) e_max_ed = ad;
        end
    endtask

    // Entered and left at a falling edge; leaves start low.
    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Feeds the queued samples; returns at the falling edge after the last accept.
    task automatic drive_run(input int gap_mode, input bit mid_start,
                             output int n_acc, output bit timed_out);
        int idx = 0;
        int cyc = 0;
        bit v;
        bit ready_s;
        timed_out = 1'b0;
        while (idx < qa.size()) begin
            if (cyc >= 200) begin
                timed_out = 1'b1;
                break;
            end
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            m_if.in_valid = v;
            if (v) begin
                m_if.a = 8'(qa[idx]); m_if.b = 8'(qb[idx]); m_if.r_approx = 16'(qr[idx]);
            end else begin
                m_if.a = 8'($urandom); m_if.b = 8'($urandom); m_if.r_approx = 16'($urandom);
            end
            start   = mid_start && (cyc == 3);
            ready_s = m_if.in_ready;
            @(posedge clk);
            if (v && ready_s) idx++;
            cyc++;
            @(negedge clk);
        end
        m_if.in_valid = 1'b0;
        start         = 1'b0;
        n_acc         = idx;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; m_if.in_valid = 1'b0;
        m_if.a = '0; m_if.b = '0; m_if.r_approx = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({m_if.in_ready, busy, done} !== 3'b000) begin
            tests_failed++; $display("FAIL reset_ctrl: got %b want 000", {m_if.in_ready, busy, done});
        end
        tests_run++;
        if (sum_ed !== '0 || max_ed !== '0 || err_cnt !== '0 || sum_err !== '0) begin
            tests_failed++;
            $display("FAIL reset_results: got %0d/%0d/%0d/%0d want 0/0/0/0", sum_ed, max_ed, err_cnt, sum_err);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_exact();
        int n; bit to;
        clear_q();
        push(3, 5, 15); push(255, 255, 65025); push(0, 7, 0); push(16, 16, 256);
        do_start();
        tests_run++;
        if (m_if.in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL exact_start_latency: in_ready got %b want 1", m_if.in_ready);
        end
        drive_run(0, 1'b0, n, to);
        tests_run++;
        if (to || n != 4) begin
            tests_failed++; $display("FAIL exact_accepts: got %0d (timeout %0d) want 4", n, to);
        end
        tests_run++;
        if ({m_if.in_ready, busy, done} !== 3'b010) begin
            tests_failed++; $display("FAIL exact_drain_k1: ready/busy/done got %b want 010", {m_if.in_ready, busy, done});
        end
        @(negedge clk);
        tests_run++;
        if ({busy, done} !== 2'b10) begin
            tests_failed++; $display("FAIL exact_drain_k2: busy/done got %b want 10", {busy, done});
        end
        @(negedge clk);
        tests_run++;
        if ({busy, done} !== 2'b01) begin
            tests_failed++; $display("FAIL exact_done_k3: busy/done got %b want 01", {busy, done});
        end
        tests_run++;
        if (sum_ed !== '0 || max_ed !== '0 || err_cnt !== '0 || sum_err !== '0) begin
            tests_failed++;
            $display("FAIL exact_results: got %0d/%0d/%0d/%0d want 0/0/0/0", sum_ed, max_ed, err_cnt, sum_err);
        end
    endtask

    task automatic test_offset();
        int n; bit to, ok;
        int a, b;
        clear_q();
        for (int i = 0; i < 4; i++) begin
            a = $urandom_range(0, 255); b = $urandom_range(0, 255);
            push(a, b, a * b + 3);
        end
        do_start();
        drive_run(0, 1'b0, n, to);
        wait_done(ok);
        tests_run++;
        if (to || !ok) begin
            tests_failed++; $display("FAIL offset_complete: timeout %0d done %0d want 0 1", to, ok);
        end
        tests_run++;
        if (sum_ed !== SW'(12) || max_ed !== 16'd3 || err_cnt !== CW'(4) || longint'(sum_err) != 12) begin
            tests_failed++;
            $display("FAIL offset_results: got %0d/%0d/%0d/%0d want 12/3/4/12", sum_ed, max_ed, err_cnt, sum_err);
        end
        // in_valid outside RUN must not disturb the held results.
        for (int i = 0; i < 3; i++) begin
            m_if.in_valid = 1'b1; m_if.a = 8'($urandom); m_if.b = 8'($urandom); m_if.r_approx = 16'($urandom);
            @(negedge clk);
        end
        m_if.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (m_if.in_ready !== 1'b0 || done !== 1'b1 || sum_ed !== SW'(12) || err_cnt !== CW'(4)) begin
            tests_failed++;
            $display("FAIL offset_hold: ready/done/sum_ed/err_cnt got %b/%b/%0d/%0d want 0/1/12/4", m_if.in_ready, done, sum_ed, err_cnt);
        end
    endtask

    task automatic test_mixed_sign();
        int n; bit to, ok;
        int a, b;
        clear_q();
        for (int i = 0; i < 4; i++) begin
            a = $urandom_range(4, 255); b = $urandom_range(4, 255);
            case (i)
                0:       push(a, b, a * b + 5);
                1:       push(a, b, a * b - 10);
                default: push(a, b, a * b);
            endcase
        end
        do_start();
        tests_run++;
        if (sum_ed !== '0 || err_cnt !== '0 || sum_err !== '0) begin
            tests_failed++; $display("FAIL mixed_clear_on_start: got %0d/%0d/%0d want 0/0/0", sum_ed, err_cnt, sum_err);
        end
        drive_run(0, 1'b0, n, to);
        wait_done(ok);
        tests_run++;
        if (to || !ok || sum_ed !== SW'(15) || max_ed !== 16'd10 || err_cnt !== CW'(2)) begin
            tests_failed++;
            $display("FAIL mixed_results: got %0d/%0d/%0d want 15/10/2 (timeout %0d done %0d)", sum_ed, max_ed, err_cnt, to, ok);
        end
        tests_run++;
        if (sum_err !== (SW+1)'(20'hFFFFB)) begin
            tests_failed++; $display("FAIL mixed_sum_err: got %h want fffffb pattern (-5)", sum_err);
        end
    endtask

    task automatic test_extreme();
        int n; bit to, ok;
        clear_q();
        for (int i = 0; i < 4; i++) push(255, 255, 0);
        do_start();
        drive_run(0, 1'b0, n, to);
        wait_done(ok);
        tests_run++;
        if (to || !ok || max_ed !== 16'd65025 || sum_ed !== SW'(260100) || err_cnt !== CW'(4)) begin
            tests_failed++;
            $display("FAIL extreme_results: got %0d/%0d/%0d want 260100/65025/4", sum_ed, max_ed, err_cnt);
        end
        tests_run++;
        if (longint'(sum_err) != -260100) begin
            tests_failed++; $display("FAIL extreme_sum_err: got %0d want -260100", sum_err);
        end
    endtask

    task automatic test_gapped_midstart();
        int n; bit to, ok;
        int a, b;
        clear_q();
        for (int i = 0; i < 4; i++) begin
            a = $urandom_range(0, 255); b = $urandom_range(0, 255);
            push(a, b, $urandom_range(0, 65535));
        end
        model(4);
        do_start();
        drive_run(1, 1'b1, n, to);
        tests_run++;
        if (to || n != 4 || m_if.in_ready !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL gapped_accepts: n %0d ready %b busy %b (timeout %0d) want 4 0 1", n, m_if.in_ready, busy, to);
        end
        wait_done(ok);
        tests_run++;
        if (!ok || longint'(sum_ed) != e_sum_ed || longint'(max_ed) != e_max_ed ||
            longint'(err_cnt) != e_err_cnt || longint'(sum_err) != e_sum_err) begin
            tests_failed++;
            $display("FAIL gapped_results: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", sum_ed, max_ed, err_cnt, sum_err,
                     e_sum_ed, e_max_ed, e_err_cnt, e_sum_err);
        end
    endtask

    task automatic test_reset_midrun();
        int n; bit to, ok;
        int a, b;
        clear_q();
        for (int i = 0; i < 2; i++) begin
            a = $urandom_range(0, 255); b = $urandom_range(0, 255);
            push(a, b, a * b + 7);
        end
        do_start();
        drive_run(0, 1'b0, n, to);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if ({m_if.in_ready, busy, done} !== 3'b000 || sum_ed !== '0 || max_ed !== '0 ||
            err_cnt !== '0 || sum_err !== '0) begin
            tests_failed++;
            $display("FAIL midrun_reset: ctrl %b results %0d/%0d/%0d/%0d want 000 0/0/0/0",
                     {m_if.in_ready, busy, done}, sum_ed, max_ed, err_cnt, sum_err);
        end
        start = 1'b1; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || m_if.in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL rst_beats_start: busy/ready got %b%b want 00", busy, m_if.in_ready);
        end
        clear_q();
        for (int i = 0; i < 4; i++) begin
            a = $urandom_range(0, 255); b = $urandom_range(0, 255);
            push(a, b, 16'(a * b + $urandom_range(0, 40) - 20));
        end
        model(4);
        do_start();
        drive_run(0, 1'b0, n, to);
        wait_done(ok);
        tests_run++;
        if (to || !ok || longint'(sum_ed) != e_sum_ed || longint'(max_ed) != e_max_ed ||
            longint'(err_cnt) != e_err_cnt || longint'(sum_err) != e_sum_err) begin
            tests_failed++;
            $display("FAIL midrun_rerun: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", sum_ed, max_ed, err_cnt, sum_err,
                     e_sum_ed, e_max_ed, e_err_cnt, e_sum_err);
        end
    endtask

    task automatic test_random();
        int n; bit to, ok;
        int a, b, p, r, mode;
        for (int run = 0; run < 8; run++) begin
            clear_q();
            mode = $urandom_range(0, 2);
            for (int i = 0; i < 4; i++) begin
                a = $urandom_range(0, 255); b = $urandom_range(0, 255); p = a * b;
                case (mode)
                    0:       r = p;
                    1:       r = p + $urandom_range(0, 200) - 100;
                    default: r = $urandom_range(0, 65535);
                endcase
                if (r < 0) r = 0;
                if (r > 65535) r = 65535;
                push(a, b, r);
            end
            model(4);
            do_start();
            drive_run($urandom_range(0, 2), 1'($urandom_range(0, 1)), n, to);
            wait_done(ok);
            tests_run++;
            if (to || n != 4 || !ok || longint'(sum_ed) != e_sum_ed || longint'(max_ed) != e_max_ed ||
                longint'(err_cnt) != e_err_cnt || longint'(sum_err) != e_sum_err) begin
                tests_failed++;
                $display("FAIL random_run%0d: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d (n %0d done %0d)", run,
                         sum_ed, max_ed, err_cnt, sum_err, e_sum_ed, e_max_ed, e_err_cnt, e_sum_err, n, ok);
            end
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_offset();
        test_mixed_sign();
        test_extreme();
        test_gapped_midstart();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
